// File: rtl/systolic_skew_feeder_if.sv
// Operand interface of the systolic skew feeder: job control, input vector stream and skewed edge output.
// lane_valid exists only when SKEW_FEEDER_LANE_VALID_EN is defined.
interface systolic_skew_feeder_if #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int KW = 8
);
   logic           start;
   logic [KW-1:0]  k_len;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] in_data;
   logic [N*W-1:0] edge_out;
   logic           busy;
   logic           done;
`ifdef SKEW_FEEDER_LANE_VALID_EN
   logic [N-1:0]   lane_valid;
`endif

   modport master (
      output start, k_len, in_valid, in_data,
`ifdef SKEW_FEEDER_LANE_VALID_EN
      input  lane_valid,
`endif
      input  in_ready, edge_out, busy, done
   );

   modport slave (
      input  start, k_len, in_valid, in_data,
`ifdef SKEW_FEEDER_LANE_VALID_EN
      output lane_valid,
`endif
      output in_ready, edge_out, busy, done
   );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Feeds one edge of an N-lane systolic array: lane i is delayed i extra cycles, bubbles are zero.
// Optional per-lane valid flags under SKEW_FEEDER_LANE_VALID_EN.
module systolic_skew_feeder #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int KW = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   systolic_skew_feeder_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t        r_state;
   logic [KW-1:0] r_k_len;
   logic [KW-1:0] r_beat;
   logic [KW-1:0] r_flush;
   logic          r_busy;
   logic          r_done;
   logic          w_accept;
   logic          w_last_beat;

   assign w_accept     = bus.in_valid && (r_state == ST_STREAM);
   // Comparing against k_len-1 keeps the counter below k_len, so the maximum k_len never wraps.
   assign w_last_beat  = (r_beat == (r_k_len - KW'(1)));
   assign bus.in_ready = (r_state == ST_STREAM);
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;

   // Job sequencer with registered busy/done.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_k_len <= {KW{1'b0}};
         r_beat  <= {KW{1'b0}};
         r_flush <= {KW{1'b0}};
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_k_len <= bus.k_len;
                  r_beat  <= {KW{1'b0}};
                  r_flush <= {KW{1'b0}};
                  if (bus.k_len != {KW{1'b0}}) begin
                     r_state <= ST_STREAM;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_STREAM: begin
               if (w_accept) begin
                  if (w_last_beat) begin
                     r_state <= ST_FLUSH;
                     r_beat  <= {KW{1'b0}};
                  end else begin
                     r_beat <= r_beat + KW'(1);
                  end
               end
            end
            ST_FLUSH: begin
               // N-1 flush cycles let the last word reach lane N-1.
               if (r_flush == KW'(N - 2)) begin
                  r_state <= ST_DONE;
                  r_flush <= {KW{1'b0}};
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_flush <= r_flush + KW'(1);
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_lane
      logic [W-1:0] r_sr [g+1];
      logic [W-1:0] w_stage0;

      assign w_stage0 = w_accept ? bus.in_data[g*W +: W] : {W{1'b0}};

      // Lane g: g-deep delay line; the last element is the edge output register.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            for (int j = 0; j <= g; j++) begin
               r_sr[j] <= {W{1'b0}};
            end
         end else begin
            r_sr[0] <= w_stage0;
            for (int j = 1; j <= g; j++) begin
               r_sr[j] <= r_sr[j-1];
            end
         end
      end

      assign bus.edge_out[g*W +: W] = r_sr[g];

`ifdef SKEW_FEEDER_LANE_VALID_EN
      logic r_v [g+1];

      // Accept flag travels alongside the data through the same skew depth.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            for (int j = 0; j <= g; j++) begin
               r_v[j] <= 1'b0;
            end
         end else begin
            r_v[0] <= w_accept;
            for (int j = 1; j <= g; j++) begin
               r_v[j] <= r_v[j-1];
            end
         end
      end

      assign bus.lane_valid[g] = r_v[g];
`endif
   end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: a job-level model predicts every cycle's outputs,
// a negedge monitor pops and compares. Honours SKEW_FEEDER_LANE_VALID_EN.
module tb_systolic_skew_feeder;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int KW = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   systolic_skew_feeder_if #(.N(N), .W(W), .KW(KW)) bus ();
   systolic_skew_feeder #(.N(N), .W(W), .KW(KW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic [N*W-1:0] edge_out;
      logic           busy;
      logic           done;
      logic           ready;
      logic [N-1:0]   lv;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   mon_done = 0;
   int   mon_busy = 0;
   int   mon_done_cyc = 0;

   // Job-level reference: beats still owed, flush cycles left, done cycle, and the stage-0 history.
   int             m_beats_left;
   int             m_flush_left;
   bit             m_done;
   logic [N*W-1:0] m_hist  [N];
   logic [N-1:0]   m_vhist [N];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_beats_left = 0;
      m_flush_left = 0;
      m_done       = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_hist[i]  = '0;
         m_vhist[i] = '0;
      end
   endtask

   function automatic exp_t model_expect();
      exp_t e;
      e.edge_out = '0;
      e.lv       = '0;
      // Lane i shows what entered the feeder i edges ago.
      for (int i = 0; i < N; i++) begin
         e.edge_out[i*W +: W] = m_hist[i][i*W +: W];
         e.lv[i]              = m_vhist[i][i];
      end
      e.busy  = (m_beats_left > 0) || (m_flush_left > 0);
      e.done  = m_done;
      e.ready = (m_beats_left > 0);
      return e;
   endfunction

   task automatic model_edge();
      logic           acc;
      logic [N*W-1:0] s0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      acc = (m_beats_left > 0) && (bus.in_valid === 1'b1);
      s0  = acc ? bus.in_data : '0;
      if (m_done) begin
         m_done = 1'b0;
      end else if (m_flush_left > 0) begin
         m_flush_left--;
         if (m_flush_left == 0) m_done = 1'b1;
      end else if (m_beats_left > 0) begin
         if (acc) begin
            m_beats_left--;
            if (m_beats_left == 0) m_flush_left = N - 1;
         end
      end else if (bus.start === 1'b1) begin
         if (bus.k_len == '0) m_done = 1'b1;
         else m_beats_left = int'(bus.k_len);
      end
      for (int i = N - 1; i > 0; i--) begin
         m_hist[i]  = m_hist[i-1];
         m_vhist[i] = m_vhist[i-1];
      end
      m_hist[0]  = s0;
      m_vhist[0] = {N{acc}};
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      sb.push_back(model_expect());
      #1;
   endtask

   task automatic assert_reset_now();
      rst_n = 1'b0;
      model_reset();
      sb.delete();
      sb.push_back(model_expect());
   endtask

   // Monitor: the DUT presents a fresh output every cycle; compare it with the oldest expectation.
   always @(negedge clk) begin
      cyc++;
      if (bus.done === 1'b1) begin
         mon_done++;
         mon_done_cyc = cyc;
      end
      if (bus.busy === 1'b1) mon_busy++;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         check("edge_out", 64'(bus.edge_out), 64'(mon_e.edge_out));
         check("busy", 64'(bus.busy), 64'(mon_e.busy));
         check("done", 64'(bus.done), 64'(mon_e.done));
         check("in_ready", 64'(bus.in_ready), 64'(mon_e.ready));
`ifdef SKEW_FEEDER_LANE_VALID_EN
         check("lane_valid", 64'(bus.lane_valid), 64'(mon_e.lv));
`endif
      end
   end

   // mode 0: valid always high; 1: one stall after the first beat; 2: random stalls and random data.
   task automatic run_job(input int k, input int mode, input bit noise);
      int   start_cyc;
      int   busy0;
      int   done0;
      int   stalls;
      int   guard;
      int   b;
      logic v;
      stalls = 0;
      guard  = 0;
      b      = 0;
      bus.start = 1'b1;
      bus.k_len = KW'(k);
      tick();
      bus.start = 1'b0;
      start_cyc = cyc;
      busy0     = mon_busy;
      done0     = mon_done;
      while (m_beats_left > 0 && guard < 5000) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = !(b == 1 && stalls == 0);
            default: v = ($urandom_range(99) >= 30);
         endcase
         bus.in_valid = v;
         for (int i = 0; i < N; i++) begin
            bus.in_data[i*W +: W] = (mode == 2) ? W'($urandom) : W'(N * b + i + 1);
         end
         if (noise) begin
            bus.start = 1'b1;
            bus.k_len = KW'($urandom);
         end
         if (v) b++;
         else stalls++;
         tick();
         guard++;
      end
      while ((m_flush_left > 0 || m_done) && guard < 5000) begin
         bus.in_valid = noise ? 1'($urandom) : 1'b0;
         bus.in_data  = N*W'($urandom);
         tick();
         guard++;
      end
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      check("job_bounded", 64'(guard < 5000), 64'(1));
      check("done_latency", 64'(mon_done_cyc - start_cyc),
            64'((k == 0) ? 1 : (k + stalls + N)));
      check("busy_cycles", 64'(mon_busy - busy0), 64'((k == 0) ? 0 : (k + stalls + N - 1)));
      check("done_pulses", 64'(mon_done - done0), 64'(1));
   endtask

   initial begin
      int done0;
      bus.start    = 1'b0;
      bus.k_len    = '0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      model_reset();
      tick();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      run_job(3, 0, 1'b0);
      run_job(3, 1, 1'b0);
      run_job(0, 0, 1'b0);

      // Reset in the middle of a job after two accepted beats.
      bus.start = 1'b1;
      bus.k_len = KW'(4);
      tick();
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hA4A3A2A1;
      tick();
      bus.in_data  = 32'hB4B3B2B1;
      tick();
      done0 = mon_done;
      assert_reset_now();
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("no_done_after_reset", 64'(mon_done - done0), 64'(0));
      run_job(1, 0, 1'b0);

      // start held high (with random k_len) through STREAM, FLUSH and DONE.
      run_job(3, 0, 1'b1);
      run_job(2, 1, 1'b1);

      for (int j = 0; j < 12; j++) begin
         run_job($urandom_range(8, 1), 2, 1'($urandom));
         for (int i = 0; i < int'($urandom_range(2)); i++) tick();
      end
      run_job(0, 0, 1'b1);
      run_job(255, 0, 1'b0);
      run_job(5, 2, 1'b1);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
